// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, 15-entry register file with
// two combinational decode read ports, halt state machine and retire counter.
module writeback_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val,
    output logic        halted,
    output logic [2:0]  exc_stat,
    output logic [31:0] retired
);
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [2:0] ST_BUB  = 3'd0;
    localparam logic [2:0] ST_AOK  = 3'd1;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [63:0] rf [0:14];
    logic [31:0] retired_q;
    logic [2:0]  exc_q;
    logic        commit;

    // Only a retiring AOK instruction in RUN touches architectural state.
    assign commit = (state_q == S_RUN) && (W_stat == ST_AOK);

    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && W_stat != ST_BUB && W_stat != ST_AOK)
            state_d = S_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            exc_q   <= ST_AOK;
        end else begin
            state_q <= state_d;
            if (state_q == S_RUN && state_d == S_HALT)
                exc_q <= W_stat;
        end
    end

    // The W register freezes on the halting edge so it keeps the faulting instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_stat  <= ST_BUB;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (state_d == S_RUN) begin
            if (W_bubble) begin
                W_stat  <= ST_BUB;
                W_icode <= I_NOP;
                W_valE  <= '0;
                W_valM  <= '0;
                W_dstE  <= RNONE;
                W_dstM  <= RNONE;
            end else if (!W_stall) begin
                W_stat  <= M_stat;
                W_icode <= M_icode;
                W_valE  <= M_valE;
                W_valM  <= m_valM;
                W_dstE  <= M_dstE;
                W_dstM  <= M_dstM;
            end
        end
    end

    // dstM is written last so it wins when both ports target one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) rf[i] <= '0;
        end else if (commit) begin
            if (W_dstE != RNONE) rf[W_dstE] <= W_valE;
            if (W_dstM != RNONE) rf[W_dstM] <= W_valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_q <= '0;
        else if (commit && W_icode != I_NOP)
            retired_q <= retired_q + 32'd1;
    end

    assign d_rvalA  = (d_srcA == RNONE) ? 64'd0 : rf[d_srcA];
    assign d_rvalB  = (d_srcB == RNONE) ? 64'd0 : rf[d_srcB];
    assign dbg_val  = (dbg_sel == RNONE) ? 64'd0 : rf[dbg_sel];
    assign halted   = (state_q == S_HALT);
    assign exc_stat = exc_q;
    assign retired  = retired_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against an architectural reference
// model (register array, W snapshot, halt flag, retire count).
module tb_writeback_regfile;
    logic        clk = 0, rst_n = 0;
    logic [2:0]  M_stat = 0;
    logic [3:0]  M_icode = 1, M_dstE = 4'hF, M_dstM = 4'hF;
    logic [63:0] M_valE = 0, m_valM = 0;
    logic        W_stall = 0, W_bubble = 0;
    logic [2:0]  W_stat, exc_stat;
    logic [3:0]  W_icode, W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM, d_rvalA, d_rvalB, dbg_val;
    logic [3:0]  d_srcA = 4'hF, d_srcB = 4'hF, dbg_sel = 4'hF;
    logic        halted;
    logic [31:0] retired;

    int checks = 0, errors = 0;

    // reference model
    logic [63:0] m_rf [0:14];
    logic [2:0]  mw_stat, m_exc;
    logic [3:0]  mw_icode, mw_dstE, mw_dstM;
    logic [63:0] mw_valE, mw_valM;
    logic        m_halted;
    logic [31:0] m_ret;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n), .M_stat(M_stat), .M_icode(M_icode),
        .M_valE(M_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble), .W_stat(W_stat), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val), .halted(halted),
        .exc_stat(exc_stat), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rf_of(input logic [3:0] r);
        return (r == 4'hF) ? 64'd0 : m_rf[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_rf[i] = '0;
        mw_stat = 0; mw_icode = 1; mw_valE = 0; mw_valM = 0;
        mw_dstE = 4'hF; mw_dstM = 4'hF;
        m_halted = 0; m_exc = 1; m_ret = 0;
    endtask

    // One clock edge: the architectural effect of the instruction sitting in W,
    // then the W snapshot advances unless the machine stopped.
    task automatic tick();
        logic stop;
        @(posedge clk);
        stop = 0;
        if (!m_halted) begin
            if (mw_stat == 1) begin
                if (mw_dstE != 4'hF) m_rf[mw_dstE] = mw_valE;
                if (mw_dstM != 4'hF) m_rf[mw_dstM] = mw_valM;
                if (mw_icode != 1) m_ret = m_ret + 1;
            end else if (mw_stat != 0) begin
                stop = 1; m_halted = 1; m_exc = mw_stat;
            end
            if (!stop) begin
                if (W_bubble) begin
                    mw_stat = 0; mw_icode = 1; mw_valE = 0; mw_valM = 0;
                    mw_dstE = 4'hF; mw_dstM = 4'hF;
                end else if (!W_stall) begin
                    mw_stat = M_stat; mw_icode = M_icode; mw_valE = M_valE;
                    mw_valM = m_valM; mw_dstE = M_dstE; mw_dstM = M_dstM;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_m(input logic [2:0] st, input logic [3:0] ic,
                           input logic [3:0] de, input logic [3:0] dm,
                           input logic [63:0] ve, input logic [63:0] vm);
        M_stat = st; M_icode = ic; M_dstE = de; M_dstM = dm; M_valE = ve; m_valM = vm;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        drive_m(1, 3, 3, 4'hF, 64'd5, 0);
        tick(); tick(); tick();
        d_srcA = 3; #1;
        checks++;
        if (d_rvalA !== 64'd5) begin errors++; $display("FAIL pre_reset_rf3 got %h want 5", d_rvalA); end
        @(posedge clk); #2;
        rst_n = 0; #1;
        model_reset();
        checks++;
        if ({W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} !== {3'd0, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF}) begin
            errors++; $display("FAIL reset_w got stat=%0d icode=%0d dstE=%h dstM=%h", W_stat, W_icode, W_dstE, W_dstM);
        end
        checks++;
        if ({halted, exc_stat, retired} !== {1'b0, 3'd1, 32'd0}) begin
            errors++; $display("FAIL reset_ctl got halted=%b exc=%0d ret=%0d want 0/1/0", halted, exc_stat, retired);
        end
        checks++;
        if (d_rvalA !== 64'd0) begin errors++; $display("FAIL reset_rf3 got %h want 0", d_rvalA); end
        for (int r = 0; r < 16; r++) begin
            dbg_sel = r[3:0]; #1;
            checks++;
            if (dbg_val !== 64'd0) begin errors++; $display("FAIL reset_dbg r%0d got %h want 0", r, dbg_val); end
        end
        drive_m(0, 1, 4'hF, 4'hF, 0, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_commit();
        drive_m(1, 3, 2, 4'hF, 64'h1234, 0);
        tick();
        drive_m(0, 1, 4'hF, 4'hF, 0, 0);
        tick();
        d_srcA = 2; d_srcB = 4'hF; #1;
        checks++;
        if (d_rvalA !== 64'h1234 || d_rvalA !== rf_of(2)) begin
            errors++; $display("FAIL commit_rf2 got %h want 1234", d_rvalA);
        end
        checks++;
        if (retired !== 32'd1 || retired !== m_ret) begin
            errors++; $display("FAIL commit_retired got %0d want 1", retired);
        end
        checks++;
        if (d_rvalB !== 64'd0) begin errors++; $display("FAIL read_none got %h want 0", d_rvalB); end
    endtask

    task automatic test_dual_write();
        drive_m(1, 11, 4, 4, 64'h10, 64'h20);
        tick();
        drive_m(1, 5, 1, 2, 64'hAAAA, 64'hBBBB);
        tick();
        drive_m(0, 1, 4'hF, 4'hF, 0, 0);
        d_srcA = 4; #1;
        checks++;
        if (d_rvalA !== 64'h20 || d_rvalA !== rf_of(4)) begin
            errors++; $display("FAIL dual_same got %h want 20", d_rvalA);
        end
        tick();
        d_srcA = 1; d_srcB = 2; #1;
        checks++;
        if (d_rvalA !== 64'hAAAA || d_rvalB !== 64'hBBBB) begin
            errors++; $display("FAIL dual_diff got %h/%h want aaaa/bbbb", d_rvalA, d_rvalB);
        end
    endtask

    task automatic test_stall_bubble();
        logic [31:0] r0;
        W_bubble = 1;
        drive_m(1, 3, 6, 4'hF, 64'h77, 0);
        tick();
        W_bubble = 0; W_stall = 1;
        r0 = retired;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (W_stat !== 3'd0 || W_dstE !== 4'hF || W_icode !== 4'd1 || retired !== r0) begin
                errors++; $display("FAIL stall_hold c%0d got stat=%0d dstE=%h ret=%0d", i, W_stat, W_dstE, retired);
            end
        end
        W_stall = 0;
        tick();
        checks++;
        if (W_dstE !== 4'd6 || W_valE !== 64'h77) begin
            errors++; $display("FAIL stall_release got dstE=%h valE=%h want 6/77", W_dstE, W_valE);
        end
        W_bubble = 1; W_stall = 1;
        drive_m(1, 3, 7, 4'hF, 64'h99, 0);
        tick();
        d_srcA = 6; d_srcB = 7; #1;
        checks++;
        if (d_rvalA !== 64'h77 || retired !== r0 + 1 || retired !== m_ret) begin
            errors++; $display("FAIL stall_one_commit got rf6=%h ret=%0d want 77/%0d", d_rvalA, retired, r0 + 1);
        end
        checks++;
        if (W_dstE !== 4'hF || W_icode !== 4'd1 || W_stat !== 3'd0) begin
            errors++; $display("FAIL bubble_w got dstE=%h icode=%0d stat=%0d", W_dstE, W_icode, W_stat);
        end
        tick();
        checks++;
        if (d_rvalB !== rf_of(7) || retired !== m_ret) begin
            errors++; $display("FAIL bubble_nowrite got rf7=%h ret=%0d want %h/%0d", d_rvalB, retired, rf_of(7), m_ret);
        end
        W_bubble = 0; W_stall = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive_m(($urandom_range(0, 3) != 0) ? 3'd1 : 3'd0, 4'($urandom_range(0, 11)),
                    ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                    {$urandom, $urandom}, {$urandom, $urandom});
            W_stall  = ($urandom_range(0, 4) == 0);
            W_bubble = ($urandom_range(0, 7) == 0);
            tick();
            d_srcA = 4'($urandom_range(0, 15)); d_srcB = 4'($urandom_range(0, 15)); #1;
            checks++;
            if ({W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} !==
                {mw_stat, mw_icode, mw_valE, mw_valM, mw_dstE, mw_dstM}) begin
                errors++; $display("FAIL rand_w n%0d got stat=%0d dstE=%h valE=%h want %0d/%h/%h",
                                   n, W_stat, W_dstE, W_valE, mw_stat, mw_dstE, mw_valE);
            end
            checks++;
            if (d_rvalA !== rf_of(d_srcA) || d_rvalB !== rf_of(d_srcB) || retired !== m_ret || halted !== 1'b0) begin
                errors++; $display("FAIL rand_rf n%0d got A=%h B=%h ret=%0d want %h/%h/%0d",
                                   n, d_rvalA, d_rvalB, retired, rf_of(d_srcA), rf_of(d_srcB), m_ret);
            end
        end
        W_stall = 0; W_bubble = 0;
    endtask

    task automatic test_wrap();
        W_bubble = 1;
        tick();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFF_FFFF;
        W_bubble = 0;
        drive_m(1, 6, 8, 4'hF, 64'h5, 0);
        tick();
        checks++;
        if (retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got %h want ffffffff", retired); end
        W_bubble = 1;
        tick();
        checks++;
        if (retired !== 32'd0 || retired !== m_ret) begin
            errors++; $display("FAIL wrap got %h want 0", retired);
        end
        W_bubble = 0;
    endtask

    task automatic test_halt(input logic [2:0] code);
        logic [63:0] r5;
        logic [31:0] rr;
        apply_reset();
        drive_m(1, 3, 5, 4'hF, 64'h55, 0);
        tick();
        drive_m(code, 6, 5, 4'hF, 64'hDEAD, 0);
        tick();
        drive_m(1, 3, 9, 4'hF, 64'h99, 0);
        tick();
        dbg_sel = 5; #1;
        r5 = dbg_val; rr = retired;
        checks++;
        if (halted !== 1'b1 || exc_stat !== code || exc_stat !== m_exc) begin
            errors++; $display("FAIL halt_state code%0d got halted=%b exc=%0d", code, halted, exc_stat);
        end
        checks++;
        if (r5 !== 64'h55 || W_stat !== code || rr !== 32'd1) begin
            errors++; $display("FAIL halt_nowrite code%0d got rf5=%h Wstat=%0d ret=%0d want 55/%0d/1", code, r5, W_stat, rr, code);
        end
        for (int i = 0; i < 4; i++) begin
            drive_m(1, 3, 4'(i), 4'hF, {$urandom, $urandom}, 0);
            W_bubble = (i == 2);
            tick();
        end
        W_bubble = 0;
        d_srcA = 9; #1;
        checks++;
        if (halted !== 1'b1 || retired !== rr || W_stat !== code || W_dstE !== 4'd5 || d_rvalA !== 64'd0 || dbg_val !== r5) begin
            errors++; $display("FAIL halt_frozen code%0d got halted=%b ret=%0d dstE=%h rf9=%h", code, halted, retired, W_dstE, d_rvalA);
        end
    endtask

    initial begin
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1;
        test_reset();
        test_commit();
        test_dual_write();
        test_stall_bubble();
        test_random();
        test_wrap();
        test_halt(3'd3);
        test_halt(3'd2);
        test_halt(3'd4);
        test_halt(3'd7);
        apply_reset();
        #1;
        checks++;
        if (halted !== 1'b0 || exc_stat !== 3'd1 || retired !== 32'd0) begin
            errors++; $display("FAIL halt_exit got halted=%b exc=%0d ret=%0d", halted, exc_stat, retired);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and architectural register file of the pipelined Y86-64 core; the write-side counterpart of the decode stage. Latches the memory-stage result into the W pipeline register, commits valE/valM to the 15-entry register file, and serves the decode stage's two combinational read ports. Also owns the processor halt state machine and a retired-instruction counter.

## Interface
- No parameters. Widths fixed: data 64, register ID 4, stat 3, icode 4.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- M_stat  in  3  memory-stage status: 0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS
- M_icode  in  4  memory-stage icode
- M_valE  in  64  ALU result
- m_valM  in  64  data-memory read value
- M_dstE, M_dstM  in  4 each  destination registers; 4'hF = none
- W_stall  in  1  hold W register
- W_bubble  in  1  load bubble into W register; overrides W_stall
- W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  3/4/64/64/4/4  registered W stage, also fed to decode forwarding
- d_srcA, d_srcB  in  4 each  decode read addresses
- d_rvalA, d_rvalB  out  64 each  combinational read data
- dbg_sel  in  4  debug register select
- dbg_val  out  64  combinational rf[dbg_sel]; 0 for 4'hF
- halted  out  1  high in HALT state
- exc_stat  out  3  stat that caused the halt; 1 (AOK) while running
- retired  out  32  count of committed instructions

## Operation
- Register file: 15 x 64-bit entries, IDs 0-14 (4 = %rsp). ID 4'hF reads 0, never written.
- Reads: combinational, no internal write bypass; same-cycle hazards are covered by decode forwarding from W_dstE/W_dstM.
- Commit, each rising edge in RUN with W_stat == 1:
  - W_dstE != F: rf[W_dstE] <= W_valE
  - W_dstM != F: rf[W_dstM] <= W_valM
  - both equal: valM wins (popq %rsp)
- No rf write when W_stat != 1 (bubble or exception) or in HALT.
- W register update, priority order:
  - HALT: hold
  - W_bubble: stat 0, icode 1 (nop), valE/valM 0, dstE/dstM F
  - W_stall: hold
  - otherwise: load from M_*
- Halt FSM, two states:
  - RUN -> HALT on an edge where W_stat is not 0 or 1 (HLT, ADR, INS, any undefined code); exc_stat <= W_stat.
  - The halting instruction does not write.
  - HALT is absorbing; only reset exits.
- retired: +1 on each RUN edge with W_stat == 1 and W_icode != 1; wraps 0xFFFF_FFFF -> 0. Frozen in HALT.

## Timing
- Reset (async assert, sync release by system):
  - W_stat 0, W_icode 1, W_valE/W_valM 0, W_dstE/W_dstM F
  - all rf entries 0
  - state RUN, halted 0, exc_stat 1, retired 0
- Reset mid-operation discards any pending commit and clears the rf.
- Latency: M-stage values appear on W_* one edge after capture; rf update one further edge; visible on d_rval* immediately after that edge.
- halted rises on the same edge that commits the transition; the W register freezes from that edge on.
- W_bubble and W_stall both high: bubble.

## Test plan
- Reset: rst_n low mid-run with rf[3]=5 -> all outputs at reset values, d_rvalA for srcA=3 reads 0, retired 0.
- Commit/read: M_dstE=2, M_valE=0x1234, AOK, no stall -> after 2 edges d_srcA=2 reads 0x1234, retired=1; d_srcB=F reads 0.
- Dual write: dstE=dstM=4, valE=0x10, valM=0x20 -> rf[4]=0x20. dstE=1, dstM=2 -> both written.
- Stall/bubble: hold W_stall 3 cycles -> W_* constant, one commit only, retired +1. Assert W_bubble -> W_dstE=F, W_icode=1, no write, retired unchanged.
- Halt: W_stat=3 (ADR), dstE=5 -> rf[5] unchanged, halted=1, exc_stat=3. Further M inputs ignored and retired frozen until rst_n.
- Wrap: preload retired to 0xFFFF_FFFF, commit one AOK instruction -> retired 0.
